// File: rtl/rr_arbiter_weighted_slice_if.sv
// Request/grant bundle between N bus masters and the weighted round-robin arbiter.
// The master side drives requests and slice lengths; the arbiter returns the grant.
interface rr_arbiter_weighted_slice_if #(
  parameter int N       = 4,
  parameter int SLICE_W = 4,
  parameter int IDW     = $clog2(N)
);
  logic [N-1:0]         REQ;
  logic [N*SLICE_W-1:0] SLICE;
  logic [N-1:0]         GNT;
  logic                 GNT_VLD;
  logic [IDW-1:0]       GNT_ID;

  modport master (output REQ, SLICE, input GNT, GNT_VLD, GNT_ID);
  modport slave  (input REQ, SLICE, output GNT, GNT_VLD, GNT_ID);
endinterface

// File: rtl/rr_arbiter_weighted_slice.sv
// N-way round-robin arbiter; each grantee keeps the resource for its own
// programmable slice, or hands it over early when its request drops.
module rr_arbiter_weighted_slice #(
  parameter int N       = 4,
  parameter int SLICE_W = 4,
  parameter int IDW     = $clog2(N)
) (
  input logic clk,
  input logic rst,
  rr_arbiter_weighted_slice_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [N-1:0]         gnt_q, gnt_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [SLICE_W-1:0]   cnt_q, cnt_d;
  logic                 vld_q;

  logic                 found;
  logic [IDW-1:0]       win;
  logic [SLICE_W-1:0]   slice_win;
  logic [SLICE_W-1:0]   cnt_load;
  logic                 take;

  // Scan starts one past the last grantee, so the current grantee is naturally
  // the last candidate; when it has dropped its request it cannot win anyway.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr_q) + 1 + k;
      if (idx >= N) idx = idx - N;
      if (!found && bus.REQ[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign slice_win = bus.SLICE[win*SLICE_W +: SLICE_W];
  assign cnt_load  = (slice_win == '0) ? '0 : slice_win - SLICE_W'(1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) take = 1'b1;
      end
      GRANT: begin
        if (!bus.REQ[ptr_q]) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            cnt_d   = '0;
          end
        end else if (cnt_q == '0) begin
          take = 1'b1;
        end else begin
          cnt_d = cnt_q - SLICE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A new grant samples the winner's slice exactly once.
    if (take) begin
      state_d    = GRANT;
      gnt_d      = '0;
      gnt_d[win] = 1'b1;
      ptr_d      = win;
      id_d       = win;
      cnt_d      = cnt_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= IDW'(N - 1);
      id_q    <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      vld_q   <= |gnt_d;
    end
  end

  assign bus.GNT     = gnt_q;
  assign bus.GNT_VLD = vld_q;
  assign bus.GNT_ID  = id_q;

endmodule

// File: tb/tb_rr_arbiter_weighted_slice.sv
// Directed bench for the weighted round-robin arbiter: a per-cycle vector table
// plus hand-written early-release and slice-sampling sequences.
module tb_rr_arbiter_weighted_slice;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rr_arbiter_weighted_slice_if #(.N(4), .SLICE_W(4)) bus ();

  rr_arbiter_weighted_slice #(.N(4), .SLICE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] slice;
    logic [3:0]  gnt;
    logic [1:0]  id;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic r, input logic [3:0] q, input logic [15:0] s,
                     input logic [3:0] g, input logic [1:0] i, input int rep);
    for (int k = 0; k < rep; k++) tbl.push_back('{r, q, s, g, i});
  endtask

  // Drive one cycle of inputs, let one edge pass, then compare all outputs.
  task automatic step(input string tag, input logic r, input logic [3:0] q,
                      input logic [15:0] s, input logic [3:0] g, input logic [1:0] i);
    logic exp_vld;
    @(negedge clk);
    rst       = r;
    bus.REQ   = q;
    bus.SLICE = s;
    @(posedge clk);
    #1;
    exp_vld = |g;
    n_vec++;
    if (bus.GNT !== g || bus.GNT_VLD !== exp_vld || bus.GNT_ID !== i) begin
      n_miss++;
      $display("FAIL %s #%0d: got GNT=%b VLD=%b ID=%0d, want GNT=%b VLD=%b ID=%0d",
               tag, n_vec, bus.GNT, bus.GNT_VLD, bus.GNT_ID, g, exp_vld, i);
    end
  endtask

  initial begin
    bus.REQ   = 4'b0000;
    bus.SLICE = 16'h0000;

    // Reset held with all requesting
    add(1, 4'hF, 16'h4321, 4'b0000, 0, 2);
    // Full contention, slices 1/2/3/4
    add(0, 4'hF, 16'h4321, 4'b0001, 0, 1);
    add(0, 4'hF, 16'h4321, 4'b0010, 1, 2);
    add(0, 4'hF, 16'h4321, 4'b0100, 2, 3);
    add(0, 4'hF, 16'h4321, 4'b1000, 3, 4);
    add(0, 4'hF, 16'h4321, 4'b0001, 0, 1);
    add(0, 4'hF, 16'h4321, 4'b0010, 1, 2);
    add(0, 4'hF, 16'h4321, 4'b0100, 2, 1);
    // Reset pulse mid-grant, then the search restarts at 0
    add(1, 4'hF, 16'h4321, 4'b0000, 0, 1);
    add(0, 4'hF, 16'h4321, 4'b0001, 0, 1);
    // Single requester, slice 3: continuous re-grant
    add(1, 4'h1, 16'h0003, 4'b0000, 0, 1);
    add(0, 4'h1, 16'h0003, 4'b0001, 0, 7);
    // Zero slice treated as one, wrap 3 -> 0
    add(1, 4'h9, 16'h0000, 4'b0000, 0, 1);
    add(0, 4'h9, 16'h0000, 4'b0001, 0, 1);
    add(0, 4'h9, 16'h0000, 4'b1000, 3, 1);
    add(0, 4'h9, 16'h0000, 4'b0001, 0, 1);
    add(0, 4'h9, 16'h0000, 4'b1000, 3, 1);

    foreach (tbl[k]) step("table", tbl[k].rst, tbl[k].req, tbl[k].slice, tbl[k].gnt, tbl[k].id);

    // Early release: 1 holds slice 8, drops after 2 cycles, 2 takes over on the same edge
    step("early_rst",   1, 4'b0110, 16'h0080, 4'b0000, 0);
    step("early_g1a",   0, 4'b0110, 16'h0080, 4'b0010, 1);
    step("early_g1b",   0, 4'b0110, 16'h0080, 4'b0010, 1);
    step("early_hand",  0, 4'b0100, 16'h0080, 4'b0100, 2);
    step("early_regnt", 0, 4'b0100, 16'h0080, 4'b0100, 2);
    step("early_idle",  0, 4'b0000, 16'h0080, 4'b0000, 0);

    // Slice sampled only at grant; non-granted REQ toggles leave the slice intact
    step("samp_rst",  1, 4'b0011, 16'h0012, 4'b0000, 0);
    step("samp_g0a",  0, 4'b0011, 16'h0012, 4'b0001, 0);
    step("samp_g0b",  0, 4'b0011, 16'h0015, 4'b0001, 0);
    step("samp_g1",   0, 4'b0011, 16'h0015, 4'b0010, 1);
    step("samp_w0",   0, 4'b0011, 16'h0015, 4'b0001, 0);
    step("samp_w1",   0, 4'b0001, 16'h0015, 4'b0001, 0);
    step("samp_w2",   0, 4'b0011, 16'h0015, 4'b0001, 0);
    step("samp_w3",   0, 4'b0001, 16'h0015, 4'b0001, 0);
    step("samp_w4",   0, 4'b0011, 16'h0015, 4'b0001, 0);
    step("samp_next", 0, 4'b0011, 16'h0015, 4'b0010, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_weighted_slice.md
# rr_arbiter_weighted_slice

Parametrised round-robin arbiter with a per-requester programmable time slice. It generalises the fixed 4-requester variable-time-slice arbiter to N requesters. Each grantee holds the grant for a configurable number of cycles, or releases early when its request drops. It sits between N bus masters and one shared resource, and drives a registered one-hot grant plus the encoded grantee index.

## Interface
- N, 4: number of requesters; N ≥ 2.
- SLICE_W, 4: width of each per-requester slice field.
- IDW, $clog2(N): width of GNT_ID.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- REQ  in  N  request vector; bit i belongs to requester i; level-sensitive.
- SLICE  in  N*SLICE_W  slice length in cycles for requester i, at bits [i*SLICE_W +: SLICE_W]; the value 0 is treated as 1.
- GNT  out  N  registered one-hot grant; all zero when idle.
- GNT_VLD  out  1  registered; equals |GNT.
- GNT_ID  out  IDW  registered index of the grantee; 0 when idle.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the resource.
- Registers:
  - gnt: one-hot grant.
  - ptr: index of the last grantee.
  - cnt: remaining slice, SLICE_W bits.
- Round-robin search:
  - Start at index (ptr+1) mod N and scan upward with wrap.
  - The first set REQ bit wins.
  - The current grantee is considered last in the order.
- On a new grant to index i:
  - ptr ← i.
  - cnt ← max(SLICE_i, 1) − 1.
  - SLICE_i is sampled only at this moment; later changes take effect at the next grant.
- IDLE:
  - If REQ == 0, stay in IDLE.
  - Otherwise, grant the search winner and go to GRANT.
- GRANT, current grantee i. Priority order on each edge:
  1. REQ[i] = 0 (early release): re-search among the other requesters. If one is found, grant it on the same edge; otherwise clear GNT and go to IDLE.
  2. cnt = 0 (slice expired): re-search starting at i+1. If only i is requesting, re-grant i with a fresh slice, with no gap cycle.
  3. Otherwise: cnt ← cnt − 1 and the grant holds.
- Arithmetic:
  - cnt never underflows; the maximum slice is 2^SLICE_W − 1 cycles.
  - The search wraps N−1 → 0.
- rst (synchronous), including mid-grant:
  - GNT = 0, GNT_VLD = 0, GNT_ID = 0.
  - ptr = N−1, so the first search starts at 0.
  - cnt = 0, state IDLE.
- REQ changes on non-granted bits never disturb an active slice.

## Timing
- All outputs are registered and change only on a rising clk edge.
- Grant latency: a request sampled at edge t appears on GNT after edge t. Worst case it is 1 cycle after the request is set up.
- A grant to i lasts exactly max(SLICE_i, 1) cycles while REQ[i] stays high.
- Handover between grantees on slice expiry or early release takes zero idle cycles.
- Early release: if REQ[i] is deasserted before edge t, GNT[i] falls after edge t.
- Worst-case wait for requester j is the sum of max(SLICE_k, 1) over all k ≠ j, plus 1 cycle.
- Reset is applied at the first edge where rst = 1 and wins over all other events.
- After rst falls, the first grant is possible at the next edge.

## Test plan
All scenarios use N = 4 and SLICE_W = 4.

- Reset: hold rst = 1 for 2 cycles with REQ = 1111 → GNT = 0000, GNT_VLD = 0, GNT_ID = 0 throughout.
- Single requester: REQ = 0001, SLICE0 = 3 → GNT = 0001 on every cycle, re-granted every 3 cycles with no gap; GNT_ID = 0.
- Full contention: REQ = 1111, SLICE = {3:4, 2:3, 1:2, 0:1} → repeating pattern 0001×1, 0010×2, 0100×3, 1000×4, with period 10 cycles.
- Early release: grant to 1 with SLICE1 = 8 and REQ = 0110; drop REQ[1] after 2 grant cycles → GNT goes 0010 → 0100 on the same edge, with no 0000 cycle.
- Zero slice and wrap: SLICE = 0 for all, REQ = 1001 → GNT alternates 0001, 1000 every cycle; GNT_ID alternates 0, 3.
- Reset mid-grant: REQ = 1111 while GNT = 0100; pulse rst for 1 cycle → GNT = 0000 after that edge, then the next grant is 0001.
